// File: rtl/regfile_hilo_pkg.sv
// Shared register-file definitions: bus types, register-file constants and sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_hilo_pkg;

  localparam int REG_NUM = 32;  // general registers, index 0 reads as zero
  localparam int REG_AW  = 5;   // register address width
  localparam int DW      = 32;  // data width

  typedef logic [DW-1:0]     RegBus;
  typedef logic [REG_AW-1:0] RegAddrBus;

  localparam int        RegNum       = REG_NUM;
  localparam RegBus     ZeroWord     = '0;
  localparam RegAddrBus NOPRegAddr   = '0;
  localparam logic      WriteEnable  = 1'b1;
  localparam logic      WriteDisable = 1'b0;
  localparam logic      RstEnable    = 1'b1;
  localparam logic      ReadEnable   = 1'b1;
  localparam logic      ChipDisable  = 1'b0;

endpackage

// File: rtl/regfile_hilo_if.sv
// Bundle of the decode read ports, write-back port and HI/LO port of the register file.
// Latency: reads combinational, writes and HI/LO take effect at the next clk edge.
// Backpressure: none; init_busy_o tells upstream to stall while the array is being cleared.
interface regfile_hilo_if;
  import regfile_hilo_pkg::*;

  logic      we;
  RegAddrBus waddr;
  RegBus     wdata;
  logic      re1;
  RegAddrBus raddr1;
  RegBus     rdata1;
  logic      re2;
  RegAddrBus raddr2;
  RegBus     rdata2;
  logic      hilo_we;
  RegBus     hi_i;
  RegBus     lo_i;
  RegBus     hi_o;
  RegBus     lo_o;
  logic      init_busy_o;

  // master: decode / write-back side
  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2, hilo_we, hi_i, lo_i,
    input  rdata1, rdata2, hi_o, lo_o, init_busy_o
  );

  // slave: the register file itself
  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2, hilo_we, hi_i, lo_i,
    output rdata1, rdata2, hi_o, lo_o, init_busy_o
  );

endinterface

// File: rtl/regfile_hilo_hilo_reg.sv
// HI/LO special-register pair; loads both halves together when enabled and ready.
// Latency: one clk edge from i_we to o_hi/o_lo; no bypass. Async reset clears both.
// Backpressure: none; writes offered while i_ready is low are dropped.
// Ports: clk/rst, i_ready (gate), i_we, i_hi, i_lo, o_hi, o_lo.
module hilo_reg
  import regfile_hilo_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_ready,
  input  logic  i_we,
  input  RegBus i_hi,
  input  RegBus i_lo,
  output RegBus o_hi,
  output RegBus o_lo
);

  RegBus r_hi;
  RegBus r_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_hi <= ZeroWord;
      r_lo <= ZeroWord;
    end else if (i_ready && (i_we == WriteEnable)) begin
      r_hi <= i_hi;
      r_lo <= i_lo;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/regfile_hilo.sv
// 32x32 register file with two combinational read ports, one write-back port and HI/LO.
// Latency: reads zero-latency with write-through bypass; writes land at the next clk edge.
// Backpressure: init_busy_o is high for 31 cycles after reset while the array is zeroed;
// all writes offered during that time are dropped, reads return zero.
// Ports: clk, rst (async, active-high), bus (regfile_hilo_if.slave).
module regfile_hilo
  import regfile_hilo_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  regfile_hilo_if.slave  bus
);

  typedef enum logic {
    STATE_CLEAR = 1'b0,
    STATE_READY = 1'b1
  } state_t;

  state_t    r_state;
  state_t    w_state_nxt;
  RegAddrBus r_clr_idx;
  RegAddrBus w_clr_idx_nxt;
  RegBus     r_regs [RegNum];
  logic      w_busy;
  logic      w_rst_act;

  assign w_busy    = (r_state == STATE_CLEAR);
  assign w_rst_act = (rst == RstEnable);

  // Sequencer state; entry 0 is never stored so clearing starts at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_state   <= STATE_CLEAR;
      r_clr_idx <= RegAddrBus'(1);
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      STATE_CLEAR: begin
        if (r_clr_idx == RegAddrBus'(RegNum - 1)) begin
          w_state_nxt = STATE_READY;
        end else begin
          w_clr_idx_nxt = r_clr_idx + RegAddrBus'(1);
        end
      end
      STATE_READY: begin
        w_state_nxt = STATE_READY;
      end
      default: begin
        w_state_nxt = STATE_CLEAR;
      end
    endcase
  end

  // Storage has no reset: the clear sequence provides the known state.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_regs[r_clr_idx] <= ZeroWord;
    end else if ((bus.we == WriteEnable) && (bus.waddr != NOPRegAddr)) begin
      r_regs[bus.waddr] <= bus.wdata;
    end
  end

  // Read priority: reset, clearing, port disabled, r0, bypass, array.
  function automatic RegBus read_port(
    input logic      busy,
    input logic      in_rst,
    input logic      re,
    input RegAddrBus ra,
    input logic      we,
    input RegAddrBus wa,
    input RegBus     wd,
    input RegBus     stored
  );
    RegBus v;
    if (in_rst || busy || (re == ChipDisable) || (ra == NOPRegAddr)) begin
      v = ZeroWord;
    end else if ((we == WriteEnable) && (wa == ra)) begin
      v = wd;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  assign bus.rdata1 = read_port(w_busy, w_rst_act, bus.re1, bus.raddr1,
                                bus.we, bus.waddr, bus.wdata, r_regs[bus.raddr1]);
  assign bus.rdata2 = read_port(w_busy, w_rst_act, bus.re2, bus.raddr2,
                                bus.we, bus.waddr, bus.wdata, r_regs[bus.raddr2]);

  assign bus.init_busy_o = w_busy;

  hilo_reg u_hilo (
    .clk     (clk),
    .rst     (rst),
    .i_ready (~w_busy),
    .i_we    (bus.hilo_we),
    .i_hi    (bus.hi_i),
    .i_lo    (bus.lo_i),
    .o_hi    (bus.hi_o),
    .o_lo    (bus.lo_o)
  );

endmodule

// File: tb/tb_regfile_hilo.sv
// Bench for regfile_hilo: directed vectors, a behavioural model checked every negedge,
// plus literal expectations at the points of interest.
module tb_regfile_hilo;

  logic clk;
  logic rst;

  regfile_hilo_if bus();

  regfile_hilo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counts clean posedges since reset; the clear takes 31 of them
  // and leaves every register at zero.
  logic [31:0] m_mem [32];
  int          m_cnt = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;

  function automatic logic m_busy();
    return (rst === 1'b1) || (m_cnt < 31);
  endfunction

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
    if (m_busy() || !re || ra == 5'd0) return 32'h0;
    if (bus.we && bus.waddr == ra) return bus.wdata;
    return m_mem[ra];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0;
      m_hi  = '0;
      m_lo  = '0;
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
    end else if (m_cnt < 31) begin
      m_cnt = m_cnt + 1;
    end else begin
      if (bus.we && bus.waddr != 5'd0) m_mem[bus.waddr] = bus.wdata;
      if (bus.hilo_we) begin
        m_hi = bus.hi_i;
        m_lo = bus.lo_i;
      end
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rdata1", bus.rdata1, exp_rd(bus.re1, bus.raddr1));
      check("model_rdata2", bus.rdata2, exp_rd(bus.re2, bus.raddr2));
      check("model_busy",   {31'b0, bus.init_busy_o}, {31'b0, m_busy()});
      check("model_hi",     bus.hi_o, m_hi);
      check("model_lo",     bus.lo_o, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input string name);
    int cnt;
    cnt = 0;
    while (bus.init_busy_o === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    check(name, cnt, 31);
  endtask

  initial begin
    rst = 1'b0;
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re1 = 1'b0; bus.raddr1 = '0; bus.re2 = 1'b0; bus.raddr2 = '0;
    bus.hilo_we = 1'b0; bus.hi_i = '0; bus.lo_i = '0;
    #1 rst = 1'b1;
    chk_en = 1'b1;

    // 1: reset, then clear sequence with a read of r7 pending
    bus.re1 = 1'b1; bus.raddr1 = 5'd7;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("t1_rdata1_clear", bus.rdata1, 32'h0);
    check("t1_busy_high", {31'b0, bus.init_busy_o}, 32'h1);
    check("t1_hi_reset", bus.hi_o, 32'h0);
    wait_clear("t1_clear_cycles");

    // 2: write-through bypass, then stored value
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h0000_1234;
    bus.raddr1 = 5'd5;
    #1 check("t2_bypass", bus.rdata1, 32'h0000_1234);
    tick();
    bus.we = 1'b0;
    #1 check("t2_stored", bus.rdata1, 32'h0000_1234);

    // 3: writes to r0 are discarded
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFF_FFFF;
    bus.re2 = 1'b1; bus.raddr2 = 5'd0;
    #1 check("t3_r0_bypass", bus.rdata2, 32'h0);
    tick();
    bus.we = 1'b0;
    #1 check("t3_r0_after", bus.rdata2, 32'h0);

    // 4: read enable gating and dual-port same-address read
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'hDEAD_BEEF;
    tick();
    bus.we = 1'b0;
    bus.re1 = 1'b0; bus.raddr1 = 5'd9;
    #1 check("t4_re_off", bus.rdata1, 32'h0);
    bus.re1 = 1'b1;
    #1 check("t4_re_on", bus.rdata1, 32'hDEAD_BEEF);
    bus.raddr2 = 5'd9;
    #1 check("t4_dual_p1", bus.rdata1, 32'hDEAD_BEEF);
    check("t4_dual_p2", bus.rdata2, 32'hDEAD_BEEF);

    // both ports on the bypass in the same cycle
    tick();
    bus.we = 1'b1; bus.waddr = 5'd12; bus.wdata = 32'hCAFE_F00D;
    bus.raddr1 = 5'd12; bus.raddr2 = 5'd12;
    #1 check("t4_byp_p1", bus.rdata1, 32'hCAFE_F00D);
    check("t4_byp_p2", bus.rdata2, 32'hCAFE_F00D);
    check("t4_byp_not_r9", bus.rdata1 ^ 32'hDEAD_BEEF, 32'h1453_4EE2);
    tick();
    bus.we = 1'b0;

    // 5: HI/LO registered, no bypass
    bus.hilo_we = 1'b1; bus.hi_i = 32'h1111_1111; bus.lo_i = 32'h2222_2222;
    #1 check("t5_hi_before", bus.hi_o, 32'h0);
    check("t5_lo_before", bus.lo_o, 32'h0);
    tick();
    bus.hilo_we = 1'b0;
    check("t5_hi_after", bus.hi_o, 32'h1111_1111);
    check("t5_lo_after", bus.lo_o, 32'h2222_2222);

    // 6: async reset mid-cycle, writes during clear dropped
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hA5A5_A5A5;
    tick();
    bus.we = 1'b0;
    bus.raddr1 = 5'd3; bus.raddr2 = 5'd4;
    #1 check("t6_r3_written", bus.rdata1, 32'hA5A5_A5A5);
    rst = 1'b1;
    #1 check("t6_hi_async", bus.hi_o, 32'h0);
    check("t6_lo_async", bus.lo_o, 32'h0);
    check("t6_busy_async", {31'b0, bus.init_busy_o}, 32'h1);
    check("t6_rdata_rst", bus.rdata1, 32'h0);
    bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h7777_7777;
    bus.hilo_we = 1'b1; bus.hi_i = 32'h3333_3333; bus.lo_i = 32'h4444_4444;
    #4 rst = 1'b0;
    wait_clear("t6_clear_cycles");
    bus.we = 1'b0; bus.hilo_we = 1'b0;
    #1 check("t6_r3_cleared", bus.rdata1, 32'h0);
    check("t6_r4_dropped", bus.rdata2, 32'h0);
    check("t6_hi_dropped", bus.hi_o, 32'h0);
    check("t6_lo_dropped", bus.lo_o, 32'h0);

    // model agrees with fresh writes after the second clear
    bus.we = 1'b1; bus.waddr = 5'd31; bus.wdata = 32'h0BAD_0001;
    tick();
    bus.we = 1'b0; bus.raddr1 = 5'd31;
    #1 check("t6_r31_after", bus.rdata1, 32'h0BAD_0001);
    tick();
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
